// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared constants for the microcoded control sequencer.
// Holds opcode map, FSM state enum, fetch-step numbers and jump conditions.
package ctrl_seq_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam logic [3:0] STEP_FETCH_PC  = 4'd0;
    localparam logic [3:0] STEP_FETCH_MEM = 4'd1;
    localparam logic [3:0] STEP_FETCH_CIR = 4'd2;
    localparam logic [3:0] STEP_FETCH_INC = 4'd3;
    localparam logic [3:0] STEP_FETCH_AR  = 4'd4;
    localparam logic [3:0] STEP_EX0       = 4'd5;
    localparam logic [3:0] STEP_EX1       = 4'd6;

    localparam logic [7:0] OP_ALU_LAST = 8'h05;
    localparam logic [7:0] OP_UN_FIRST = 8'h06;
    localparam logic [7:0] OP_UN_LAST  = 8'h0C;
    localparam logic [7:0] OP_NOP      = 8'h0D;
    localparam logic [7:0] OP_HLT      = 8'h0E;
    localparam logic [7:0] OP_LOAD     = 8'h0F;
    localparam logic [7:0] OP_STORE    = 8'h10;
    localparam logic [7:0] OP_MOV_RC   = 8'h11;
    localparam logic [7:0] OP_MOV_CR   = 8'h12;
    localparam logic [7:0] OP_MOV_CI   = 8'h13;
    localparam logic [7:0] OP_JMP      = 8'h14;
    localparam logic [7:0] OP_J_LAST   = 8'h1C;

    localparam logic [1:0] MODE_REG = 2'b01;

    // Jump condition index = opcode - OP_JMP
    typedef enum logic [3:0] {
        CC_ALWAYS = 4'd0,
        CC_Z      = 4'd1,
        CC_NZ     = 4'd2,
        CC_C      = 4'd3,
        CC_NC     = 4'd4,
        CC_P      = 4'd5,
        CC_N      = 4'd6,
        CC_O      = 4'd7,
        CC_NO     = 4'd8
    } cond_e;

    function automatic logic cond_met(
        input logic [3:0] sel,
        input logic       z,
        input logic       n,
        input logic       c,
        input logic       v
    );
        logic r;
        r = 1'b0;
        case (cond_e'(sel))
            CC_ALWAYS: r = 1'b1;
            CC_Z:      r = z;
            CC_NZ:     r = !z;
            CC_C:      r = c;
            CC_NC:     r = !c;
            CC_P:      r = !n;
            CC_N:      r = n;
            CC_O:      r = v;
            CC_NO:     r = !v;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cu_step_counter.sv
// cu_step_counter: 4-bit micro-step counter with run-hold, wait-hold and clear.
// Ports: clk, reset (sync, active-high), run_i, wait_i, clr_i, step_o.
module cu_step_counter
    import ctrl_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run_i,
    input  logic       wait_i,
    input  logic       clr_i,
    output logic [3:0] step_o
);

    logic [3:0] step_q;
    logic [3:0] step_d;

    // Clear wins over wait: a retiring store completes on its ready cycle.
    always_comb begin
        step_d = step_q;
        if (run_i) begin
            if (clr_i) begin
                step_d = STEP_FETCH_PC;
            end else if (!wait_i) begin
                step_d = step_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= STEP_FETCH_PC;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: control sequencer; decodes (state, step, opcode, operand, flags)
// into datapath strobes, one-hot register strobes, retire/illegal/halted.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int NREG    = 8,
    parameter int ACC_IDX = 2,
    parameter int ALUW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_run,
    input  logic [7:0]      opcode,
    input  logic [7:0]      operand,
    input  logic            Z,
    input  logic            N,
    input  logic            C,
    input  logic            V,
    input  logic            mem_ready,
    output logic            pc_out,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            cir_in,
    output logic            ar_in,
    output logic            ar_out,
    output logic            ram_rd,
    output logic            ram_wr,
    output logic            flag_in,
    output logic            acc_sel,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic [ALUW-1:0] alu_op,
    output logic [3:0]      step,
    output logic            retire,
    output logic            illegal,
    output logic            halted
);

    localparam logic [3:0] NREG_W = 4'(NREG);

    function automatic logic [NREG-1:0] oh(input logic [2:0] idx);
        logic [NREG-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            r[i] = (idx == 3'(i));
        end
        return r;
    endfunction

    state_e     state_q;
    logic [3:0] step_q;
    logic       active;
    logic       wait_c;

    logic [1:0] mode;
    logic [2:0] dest;
    logic [2:0] src;
    logic       dest_bad;
    logic       src_bad;
    logic       mode_bad;

    logic is_rr, is_un, is_nop, is_hlt, is_load, is_store;
    logic is_mrc, is_mcr, is_mci, is_jmp, bad_op, ill_c;

    logic [NREG-1:0] acc_oh;
    logic [NREG-1:0] src_oh;
    logic [NREG-1:0] dest_oh;

    assign mode     = operand[7:6];
    assign dest     = operand[5:3];
    assign src      = operand[2:0];
    assign dest_bad = ({1'b0, dest} >= NREG_W);
    assign src_bad  = ({1'b0, src} >= NREG_W);
    assign mode_bad = (mode != MODE_REG);

    assign acc_oh  = oh(3'(ACC_IDX));
    assign src_oh  = oh(src);
    assign dest_oh = oh(dest);

    assign is_rr    = (opcode <= OP_ALU_LAST);
    assign is_un    = (opcode >= OP_UN_FIRST) && (opcode <= OP_UN_LAST);
    assign is_nop   = (opcode == OP_NOP);
    assign is_hlt   = (opcode == OP_HLT);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mrc   = (opcode == OP_MOV_RC);
    assign is_mcr   = (opcode == OP_MOV_CR);
    assign is_mci   = (opcode == OP_MOV_CI);
    assign is_jmp   = (opcode >= OP_JMP) && (opcode <= OP_J_LAST);
    assign bad_op   = (opcode > OP_J_LAST);

    // Only ops that name a register in the operand check its mode/index.
    assign ill_c = bad_op
                 | (is_rr  & (mode_bad | dest_bad | src_bad))
                 | (is_mrc & (mode_bad | dest_bad))
                 | (is_mcr & (mode_bad | src_bad));

    // Reset and halt gate every output combinationally.
    assign active = !reset && cpu_run && (state_q == ST_RUN);

    assign wait_c = active && !mem_ready
                 && ((step_q == STEP_FETCH_MEM)
                  || ((step_q == STEP_EX0) && !ill_c && (is_load || is_store)));

    cu_step_counter u_step (
        .clk    (clk),
        .reset  (reset),
        .run_i  (active),
        .wait_i (wait_c),
        .clr_i  (retire),
        .step_o (step_q)
    );

    always_comb begin
        pc_out  = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        mar_in  = 1'b0;
        mdr_in  = 1'b0;
        cir_in  = 1'b0;
        ar_in   = 1'b0;
        ar_out  = 1'b0;
        ram_rd  = 1'b0;
        ram_wr  = 1'b0;
        flag_in = 1'b0;
        acc_sel = 1'b0;
        reg_in  = '0;
        reg_out = '0;
        alu_op  = '0;
        retire  = 1'b0;
        illegal = 1'b0;
        if (active) begin
            case (step_q)
                STEP_FETCH_PC: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                STEP_FETCH_MEM: begin
                    ram_rd = 1'b1;
                    mdr_in = 1'b1;
                end
                STEP_FETCH_CIR: cir_in = 1'b1;
                STEP_FETCH_INC: pc_inc = 1'b1;
                STEP_FETCH_AR:  ar_in  = 1'b1;
                STEP_EX0: begin
                    if (ill_c) begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        unique case (1'b1)
                            is_rr: begin
                                reg_out = src_oh;
                                reg_in  = dest_oh;
                                alu_op  = opcode[ALUW-1:0];
                            end
                            is_un: begin
                                reg_in = acc_oh;
                                alu_op = opcode[ALUW-1:0];
                            end
                            is_nop, is_hlt: retire = 1'b1;
                            is_load: begin
                                ram_rd = 1'b1;
                                if (mem_ready) begin
                                    reg_in  = acc_oh;
                                    acc_sel = 1'b1;
                                end
                            end
                            is_store: begin
                                reg_out = acc_oh;
                                ram_wr  = 1'b1;
                                retire  = mem_ready;
                            end
                            is_mrc: begin
                                reg_out = acc_oh;
                                reg_in  = dest_oh;
                                retire  = 1'b1;
                            end
                            is_mcr: begin
                                reg_out = src_oh;
                                reg_in  = acc_oh;
                                acc_sel = 1'b1;
                            end
                            is_mci: begin
                                ar_out  = 1'b1;
                                acc_sel = 1'b1;
                                reg_in  = acc_oh;
                            end
                            is_jmp: begin
                                if (cond_met(opcode[3:0] - 4'd4, Z, N, C, V)) begin
                                    ar_out  = 1'b1;
                                    pc_load = 1'b1;
                                end
                                retire = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                STEP_EX1: begin
                    if (!ill_c && (is_rr || is_un || is_load || is_mcr || is_mci)) begin
                        flag_in = 1'b1;
                        retire  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else if (retire && is_hlt && !ill_c && (step_q == STEP_EX0)) begin
            state_q <= ST_HALTED;
        end
    end

    assign step   = reset ? 4'd0 : step_q;
    assign halted = !reset && (state_q == ST_HALTED);

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed self-checking bench for ctrl_seq (NREG=4).
// Each task drives one scenario and compares a packed output snapshot.
module tb_ctrl_seq;

    logic       clk, reset, cpu_run;
    logic [7:0] opcode, operand;
    logic       Z, N, C, V, mem_ready;
    logic       pc_out, pc_inc, pc_load, mar_in, mdr_in, cir_in;
    logic       ar_in, ar_out, ram_rd, ram_wr, flag_in, acc_sel;
    logic [3:0] reg_in, reg_out, alu_op, step;
    logic       retire, illegal, halted;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] PCOUT  = 12'h800;
    localparam logic [11:0] PCINC  = 12'h400;
    localparam logic [11:0] PCLOAD = 12'h200;
    localparam logic [11:0] MARIN  = 12'h100;
    localparam logic [11:0] MDRIN  = 12'h080;
    localparam logic [11:0] CIRIN  = 12'h040;
    localparam logic [11:0] ARIN   = 12'h020;
    localparam logic [11:0] AROUT  = 12'h010;
    localparam logic [11:0] RAMRD  = 12'h008;
    localparam logic [11:0] RAMWR  = 12'h004;
    localparam logic [11:0] FLAGIN = 12'h002;
    localparam logic [11:0] ACCSEL = 12'h001;

    ctrl_seq #(.NREG(4), .ACC_IDX(2), .ALUW(4)) dut (
        .clk(clk), .reset(reset), .cpu_run(cpu_run),
        .opcode(opcode), .operand(operand),
        .Z(Z), .N(N), .C(C), .V(V), .mem_ready(mem_ready),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load),
        .mar_in(mar_in), .mdr_in(mdr_in), .cir_in(cir_in),
        .ar_in(ar_in), .ar_out(ar_out), .ram_rd(ram_rd),
        .ram_wr(ram_wr), .flag_in(flag_in), .acc_sel(acc_sel),
        .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op),
        .step(step), .retire(retire), .illegal(illegal),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    function automatic logic [30:0] snap();
        return {step,
                pc_out, pc_inc, pc_load, mar_in, mdr_in, cir_in,
                ar_in, ar_out, ram_rd, ram_wr, flag_in, acc_sel,
                reg_in, reg_out, alu_op, retire, illegal, halted};
    endfunction

    function automatic logic [30:0] mk(
        input logic [3:0] s, input logic [11:0] st,
        input logic [3:0] ri, input logic [3:0] ro, input logic [3:0] al,
        input logic rt, input logic il, input logic hl);
        return {s, st, ri, ro, al, rt, il, hl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs steps 0..4 from a step-0 cycle; returns positioned at step 5.
    task automatic fetch(input logic [7:0] op, input logic [7:0] opr,
                         input logic [3:0] fl);
        logic [30:0] exp;
        opcode = op;
        operand = opr;
        {Z, N, C, V} = fl;
        mem_ready = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) tick();
            case (s)
                0: exp = mk(4'd0, PCOUT | MARIN, 0, 0, 0, 0, 0, 0);
                1: exp = mk(4'd1, RAMRD | MDRIN, 0, 0, 0, 0, 0, 0);
                2: exp = mk(4'd2, CIRIN, 0, 0, 0, 0, 0, 0);
                3: exp = mk(4'd3, PCINC, 0, 0, 0, 0, 0, 0);
                default: exp = mk(4'd4, ARIN, 0, 0, 0, 0, 0, 0);
            endcase
            total++;
            if (snap() !== exp) begin
                bad++;
                $display("FAIL fetch op=%h s=%0d: got %h want %h", op, s, snap(), exp);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_run = 1'b1;
        mem_ready = 1'b0;
        opcode = 8'h00;
        operand = 8'h00;
        {Z, N, C, V} = 4'h0;
        tick();
        tick();
        total++;
        if (snap() !== 31'd0) begin
            bad++;
            $display("FAIL reset_hold: got %h want 0", snap());
        end
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        total++;
        if (snap() !== mk(4'd0, PCOUT | MARIN, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_release: got %h want step0 pc_out+mar_in", snap());
        end
    endtask

    task automatic test_two_cycle();
        logic [7:0]  ops [5] = '{8'h00, 8'h03, 8'h07, 8'h12, 8'h13};
        logic [7:0]  oprs[5] = '{8'h48, 8'h4B, 8'h00, 8'h43, 8'h00};
        logic [30:0] e5  [5];
        e5[0] = mk(4'd5, 12'h0, 4'b0010, 4'b0001, 4'h0, 0, 0, 0);
        e5[1] = mk(4'd5, 12'h0, 4'b0010, 4'b1000, 4'h3, 0, 0, 0);
        e5[2] = mk(4'd5, 12'h0, 4'b0100, 4'b0000, 4'h7, 0, 0, 0);
        e5[3] = mk(4'd5, ACCSEL, 4'b0100, 4'b1000, 4'h0, 0, 0, 0);
        e5[4] = mk(4'd5, AROUT | ACCSEL, 4'b0100, 4'b0000, 4'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            fetch(ops[i], oprs[i], 4'h0);
            total++;
            if (snap() !== e5[i]) begin
                bad++;
                $display("FAIL two_s5 op=%h: got %h want %h", ops[i], snap(), e5[i]);
            end
            tick();
            total++;
            if (snap() !== mk(4'd6, FLAGIN, 0, 0, 0, 1, 0, 0)) begin
                bad++;
                $display("FAIL two_s6 op=%h: got %h want flag_in+retire", ops[i], snap());
            end
            tick();
            total++;
            if (snap() !== mk(4'd0, PCOUT | MARIN, 0, 0, 0, 0, 0, 0)) begin
                bad++;
                $display("FAIL two_next op=%h: got %h want step0", ops[i], snap());
            end
        end
    endtask

    task automatic test_single_cycle();
        logic [7:0]  ops [16] = '{8'h0D, 8'h14, 8'h15, 8'h15, 8'h16, 8'h17,
                                  8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h11,
                                  8'h11, 8'h1D, 8'h00, 8'h12};
        logic [7:0]  oprs[16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h48,
                                  8'h70, 8'h00, 8'h08, 8'h44};
        logic [3:0]  fls [16] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h2,
                                  4'h2, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0,
                                  4'h0, 4'h0, 4'h0, 4'h0};
        logic [30:0] e5  [16];
        logic [30:0] nt, tk, il;
        nt = mk(4'd5, 12'h0, 0, 0, 0, 1, 0, 0);
        tk = mk(4'd5, AROUT | PCLOAD, 0, 0, 0, 1, 0, 0);
        il = mk(4'd5, 12'h0, 0, 0, 0, 1, 1, 0);
        e5 = '{nt, tk, nt, tk, nt, tk, nt, tk, nt, tk, nt,
               mk(4'd5, 12'h0, 4'b0010, 4'b0100, 0, 1, 0, 0),
               il, il, il, il};
        for (int i = 0; i < 16; i++) begin
            fetch(ops[i], oprs[i], fls[i]);
            total++;
            if (snap() !== e5[i]) begin
                bad++;
                $display("FAIL one_s5 i=%0d op=%h: got %h want %h", i, ops[i], snap(), e5[i]);
            end
            tick();
            total++;
            if (snap() !== mk(4'd0, PCOUT | MARIN, 0, 0, 0, 0, 0, 0)) begin
                bad++;
                $display("FAIL one_next i=%0d: got %h want step0", i, snap());
            end
        end
    endtask

    task automatic test_load_wait();
        fetch(8'h0F, 8'h00, 4'h0);
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            total++;
            if (snap() !== mk(4'd5, RAMRD, 0, 0, 0, 0, 0, 0)) begin
                bad++;
                $display("FAIL load_wait c=%0d: got %h want step5 ram_rd", i, snap());
            end
        end
        tick();
        mem_ready = 1'b1;
        #1;
        total++;
        if (snap() !== mk(4'd5, RAMRD | ACCSEL, 4'b0100, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL load_ready: got %h want ram_rd+acc_sel reg_in=4", snap());
        end
        tick();
        total++;
        if (snap() !== mk(4'd6, FLAGIN, 0, 0, 0, 1, 0, 0)) begin
            bad++;
            $display("FAIL load_s6: got %h want flag_in+retire", snap());
        end
        tick();
    endtask

    task automatic test_store_wait();
        fetch(8'h10, 8'h00, 4'h0);
        mem_ready = 1'b0;
        #1;
        total++;
        if (snap() !== mk(4'd5, RAMWR, 0, 4'b0100, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL store_wait: got %h want ram_wr reg_out=4", snap());
        end
        tick();
        mem_ready = 1'b1;
        #1;
        total++;
        if (snap() !== mk(4'd5, RAMWR, 0, 4'b0100, 0, 1, 0, 0)) begin
            bad++;
            $display("FAIL store_ready: got %h want ram_wr+retire", snap());
        end
        tick();
        total++;
        if (snap() !== mk(4'd0, PCOUT | MARIN, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL store_next: got %h want step0", snap());
        end
    endtask

    task automatic test_run_hold();
        opcode = 8'h0D;
        operand = 8'h00;
        tick();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            total++;
            if (snap() !== mk(4'd1, RAMRD | MDRIN, 0, 0, 0, 0, 0, 0)) begin
                bad++;
                $display("FAIL fetch_wait c=%0d: got %h want step1 hold", i, snap());
            end
        end
        mem_ready = 1'b1;
        tick();
        cpu_run = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++;
            if (snap() !== mk(4'd2, 12'h0, 0, 0, 0, 0, 0, 0)) begin
                bad++;
                $display("FAIL run_hold c=%0d: got %h want step2 idle", i, snap());
            end
        end
        cpu_run = 1'b1;
        #1;
        total++;
        if (snap() !== mk(4'd2, CIRIN, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL run_resume: got %h want step2 cir_in", snap());
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (snap() !== 31'd0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0", snap());
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (snap() !== mk(4'd0, PCOUT | MARIN, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_mid_release: got %h want step0", snap());
        end
    endtask

    task automatic test_halt();
        fetch(8'h0E, 8'h00, 4'h0);
        total++;
        if (snap() !== mk(4'd5, 12'h0, 0, 0, 0, 1, 0, 0)) begin
            bad++;
            $display("FAIL hlt_s5: got %h want retire", snap());
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (snap() !== mk(4'd0, 12'h0, 0, 0, 0, 0, 0, 1)) begin
                bad++;
                $display("FAIL halted c=%0d: got %h want halted only", i, snap());
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (snap() !== mk(4'd0, PCOUT | MARIN, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL hlt_reset: got %h want step0 running", snap());
        end
    endtask

    initial begin
        test_reset();
        test_two_cycle();
        test_single_cycle();
        test_load_wait();
        test_store_wait();
        test_run_hold();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have parameter NREG, default 8, number of general registers (1..8, one-hot strobes).
REQ-002 SHALL have parameter ACC_IDX, default 2, index of accumulator register (C) used by unary/LOAD/STORE/MOV-immediate.
REQ-003 SHALL have parameter ALUW, default 4, width of alu_op.
REQ-004 SHALL provide: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL provide: cpu_run  in  1  run enable; opcode  in  8  from CIR; operand  in  8  from AR (mode[7:6], dest[5:3], src[2:0]).
REQ-006 SHALL provide: Z,N,C,V  in  1 each  status flags; mem_ready  in  1  memory access complete.
REQ-007 SHALL provide: pc_out, pc_inc, pc_load, mar_in, mdr_in, cir_in, ar_in, ar_out, ram_rd, ram_wr, flag_in, acc_sel  out  1 each  datapath strobes.
REQ-008 SHALL provide: reg_in, reg_out  out  NREG  one-hot register load/drive strobes.
REQ-009 SHALL provide: alu_op  out  ALUW  opcode[ALUW-1:0] during ALU execute, else 0; step  out  4  current step.
REQ-010 SHALL provide: retire  out  1  instruction-complete pulse; illegal  out  1  illegal-instruction pulse; halted  out  1  halt state.

Function
REQ-011 SHALL hold an internal 4-bit step counter and FSM states RUN and HALTED; strobes are combinational decode of (state, step, opcode, operand, flags), all forced 0 when cpu_run=0 or state=HALTED.
REQ-012 Fetch SHALL be: step0 pc_out+mar_in; step1 ram_rd+mdr_in; step2 cir_in; step3 pc_inc; step4 ar_in.
REQ-013 Step SHALL advance by 1 per clk when cpu_run=1, hold when cpu_run=0, and hold at step1 (strobes held asserted) while mem_ready=0.
REQ-014 On a retire cycle step SHALL return to 0 on the next clk (no bubble cycle).
REQ-015 ALU reg-reg 0x00-0x05: step5 reg_out[src], reg_in[dest], alu_op; step6 flag_in+retire.
REQ-016 ALU unary 0x06-0x0C: step5 reg_in[ACC_IDX], alu_op; step6 flag_in+retire.
REQ-017 NOP 0x0D: retire at step5; HLT 0x0E: step5 retire, state->HALTED next clk, halted=1 until reset.
REQ-018 LOAD 0x0F: step5 ram_rd held until mem_ready=1; on that cycle reg_in[ACC_IDX]+acc_sel; step6 flag_in+retire.
REQ-019 STORE 0x10: step5 reg_out[ACC_IDX]+ram_wr held until mem_ready=1; retire on that cycle.
REQ-020 MOV 0x11 (Rd<-C) and 0x12 (C<-Rs, acc_sel, flag_in at step6): step5 register strobes; 0x11 retires step5, 0x12 step6.
REQ-021 MOV C,#imm 0x13: step5 ar_out+acc_sel+reg_in[ACC_IDX]; step6 flag_in+retire.
REQ-022 JMP 0x14 and Jcc 0x15-0x1C: condition JMP=1, JZ Z, JNZ !Z, JC C, JNC !C, JP !N, JN N, JO V, JNO !V sampled at step5; taken: ar_out+pc_load; step5 retire either way.
REQ-023 Opcode >0x1C, operand mode!=01 for register ops, or register index >=NREG SHALL assert illegal for one cycle at step5, suppress all register strobes, and retire (NOP behaviour).
REQ-024 reg_in and reg_out SHALL each be zero or one-hot in every cycle.

Reset
REQ-025 While reset=1 at clk: step<=0, state<=RUN; all outputs 0 during the reset cycle, including mid-instruction or mid-wait.
REQ-026 reset SHALL take priority over cpu_run, mem_ready and HALTED.

Structure
REQ-027 Opcode constants, state enum, fetch-step constants and condition encoding SHALL live in package ctrl_seq_pkg.
REQ-028 Step counter with hold/wait/clear logic SHALL be sub-module cu_step_counter; decode stays in ctrl_seq.

Verification
REQ-029 ADD opcode 0x00, operand 0x48 (mode01, dest1, src0), mem_ready=1 -> step5 reg_out=0x01, reg_in=0x02; step6 flag_in+retire; step 0 next clk.
REQ-030 LOAD 0x0F with mem_ready low 3 cycles at step5 -> step stays 5, ram_rd held 4 cycles, reg_in=0x04 only in ready cycle, retire step6.
REQ-031 JZ 0x15, Z=0 -> pc_load=0, retire step5; Z=1 -> ar_out+pc_load at step5.
REQ-032 HLT 0x0E -> halted=1 from next clk, all strobes 0 with cpu_run=1 for 10 cycles; reset -> halted=0, step0 pc_out+mar_in.
REQ-033 NREG=4, operand 0x70 (dest6) with opcode 0x11 -> illegal pulse at step5, reg_in=0, retire.
REQ-034 cpu_run dropped at step2 for 5 cycles -> step holds 2, all strobes 0; resumes with cir_in.
